// File: rtl/bmf_h_stream_decoder.sv
// rtl/bmf_h_stream_decoder.sv - programmable GF(2) basis decoder for BMF latent code streams
//
// Reconstructs M-bit partition outputs from K-bit latent codes as the XOR of
// the rows of a run-time loadable K x M basis matrix H selected by the code.
// Two registered stages: A holds the code, B holds the XOR result.
//
// Optional feature macro: BMF_H_DECODER_ERR_MON_EN (adds in_ref, err_count,
// err_bits and the per-handshake mismatch counters).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cfg_we/cfg_row/cfg_data        H row write (accepted when cfg_ready)
//   cfg_ready                      pipeline idle, a write will be accepted
//   in_valid/in_ready/in_k         latent code input handshake
//   out_valid/out_ready/out_po     reconstructed output handshake
//   in_ref, err_count, err_bits    golden reference and error counters (macro only)
module bmf_h_stream_decoder #(
    parameter int K  = 12,
    parameter int M  = 13,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [RW-1:0] cfg_row,
    input  logic [M-1:0]  cfg_data,
    output logic          cfg_ready,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [K-1:0]  in_k,
`ifdef BMF_H_DECODER_ERR_MON_EN
    input  logic [M-1:0]  in_ref,
    output logic [31:0]   err_count,
    output logic [31:0]   err_bits,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_po
);

    logic [M-1:0] h [K];

    logic         a_valid;
    logic [K-1:0] a_k;
    logic         b_valid;
    logic [M-1:0] b_po;
    logic         b_adv;
    logic         a_adv;
    logic [M-1:0] xor_po;
    logic         cfg_hit;

    // Each stage moves when it is empty or its occupant leaves this cycle.
    assign b_adv     = !b_valid || out_ready;
    assign a_adv     = !a_valid || b_adv;
    assign in_ready  = !rst && a_adv;
    assign cfg_ready = !a_valid && !b_valid && !in_valid;
    assign cfg_hit   = cfg_we && cfg_ready && (32'(cfg_row) < K);

    assign out_valid = b_valid;
    assign out_po    = b_po;

    // K-input XOR per output bit; evaluated from the stage A register only.
    always_comb begin
        xor_po = '0;
        for (int i = 0; i < K; i++) begin
            if (a_k[i]) begin
                xor_po = xor_po ^ h[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                h[i] <= '0;
            end
        end else if (cfg_hit) begin
            h[cfg_row] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_k     <= '0;
            b_valid <= 1'b0;
            b_po    <= '0;
        end else begin
            if (a_adv) begin
                a_valid <= in_valid;
                if (in_valid) begin
                    a_k <= in_k;
                end
            end
            if (b_adv) begin
                b_valid <= a_valid;
                if (a_valid) begin
                    b_po <= xor_po;
                end
            end
        end
    end

`ifdef BMF_H_DECODER_ERR_MON_EN
    logic [M-1:0]  a_ref;
    logic [M-1:0]  b_ref;
    logic [M-1:0]  diff;
    logic [31:0]   diff_pop;
    logic [32:0]   bits_sum;
    logic          out_hs;

    assign out_hs   = b_valid && out_ready;
    assign diff     = b_po ^ b_ref;
    assign bits_sum = {1'b0, err_bits} + {1'b0, diff_pop};

    always_comb begin
        diff_pop = '0;
        for (int i = 0; i < M; i++) begin
            diff_pop = diff_pop + 32'(diff[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_ref     <= '0;
            b_ref     <= '0;
            err_count <= '0;
            err_bits  <= '0;
        end else begin
            if (a_adv && in_valid) begin
                a_ref <= in_ref;
            end
            if (b_adv && a_valid) begin
                b_ref <= a_ref;
            end
            // Counting only on the handshake edge means a stalled word is seen once.
            if (out_hs && (diff != '0)) begin
                if (err_count != 32'hFFFF_FFFF) begin
                    err_count <= err_count + 32'd1;
                end
                err_bits <= bits_sum[32] ? 32'hFFFF_FFFF : bits_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_bmf_h_stream_decoder.sv
// tb/tb_bmf_h_stream_decoder.sv - scoreboard bench for bmf_h_stream_decoder
module tb_bmf_h_stream_decoder;

    localparam int K  = 12;
    localparam int M  = 13;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [RW-1:0] cfg_row = '0;
    logic [M-1:0]  cfg_data = '0;
    logic          cfg_ready;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [K-1:0]  in_k = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [M-1:0]  out_po;
    logic [M-1:0]  in_ref = '0;
`ifdef BMF_H_DECODER_ERR_MON_EN
    logic [31:0]   err_count;
    logic [31:0]   err_bits;
`endif

    int checks = 0;
    int errors = 0;

    logic [M-1:0] h_model [K];
    logic [M-1:0] q [$];
    logic [M-1:0] cur_exp = '0;
    logic         stall_prev = 1'b0;
    logic [M-1:0] stall_po = '0;

    bmf_h_stream_decoder #(.K(K), .M(M), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_row   (cfg_row),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_k      (in_k),
`ifdef BMF_H_DECODER_ERR_MON_EN
        .in_ref    (in_ref),
        .err_count (err_count),
        .err_bits  (err_bits),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_po    (out_po)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [M-1:0] hx(input logic [K-1:0] k);
        logic [M-1:0] r;
        r = '0;
        for (int i = 0; i < K; i++) begin
            if (k[i]) r = r ^ h_model[i];
        end
        return r;
    endfunction

    // Monitor samples mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_hold", 32'(out_po), 32'(stall_po));
                chk("stall_valid", 32'(out_valid), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    chk("out_po", 32'(out_po), 32'(q.pop_front()));
                end
            end
            if (in_valid && in_ready) q.push_back(cur_exp);
            stall_prev = out_valid && !out_ready;
            stall_po   = out_po;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [K-1:0] k, input logic [M-1:0] exp, input logic [M-1:0] r);
        logic hs;
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_k     = k;
        in_ref   = r;
        cur_exp  = exp;
        for (int n = 0; n < 100 && !done; n++) begin
            #1;
            hs = in_ready;
            tick();
            done = hs;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && q.size() != 0; n++) tick();
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic write_row(input logic [RW-1:0] row, input logic [M-1:0] data,
                             input logic exp_ready, input logic applies);
        cfg_we   = 1'b1;
        cfg_row  = row;
        cfg_data = data;
        #1;
        chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
        tick();
        cfg_we = 1'b0;
        if (applies) h_model[row] = data;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < K; i++) h_model[i] = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_po", 32'(out_po), 32'd0);
        chk("rst_in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [K-1:0] codes [6];
        logic         seen_drop;
        int           sent;
        logic         hs;

        for (int i = 0; i < K; i++) h_model[i] = '0;
        tick();
        do_reset();
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
`ifdef BMF_H_DECODER_ERR_MON_EN
        chk("rst_err_count", err_count, 32'd0);
        chk("rst_err_bits", err_bits, 32'd0);
`endif
        send(12'hFFF, 13'h0000, '0);
        drain();

        // Identity basis
        for (int i = 0; i < K; i++) write_row(RW'(i), M'(1) << i, 1'b1, 1'b1);
        send(12'h5A3, 13'h05A3, '0);
        drain();

        // XOR mapping
        for (int i = 0; i < K; i++) write_row(RW'(i), '0, 1'b1, 1'b1);
        write_row(4'd10, 13'h04A0, 1'b1, 1'b1);
        write_row(4'd3, 13'h00A0, 1'b1, 1'b1);
        send(12'h408, 13'h0400, '0);
        send(12'h400, 13'h04A0, '0);
        send(12'h000, 13'h0000, '0);
        drain();

        // Random basis and codes
        for (int i = 0; i < K; i++) write_row(RW'(i), M'($urandom), 1'b1, 1'b1);
        for (int n = 0; n < 8; n++) begin
            logic [K-1:0] k;
            k = K'($urandom);
            send(k, hx(k), '0);
        end
        drain();

        // Backpressure: 6 codes, out_ready low for cycles 3..7
        for (int i = 0; i < 6; i++) codes[i] = K'($urandom);
        sent = 0;
        seen_drop = 1'b0;
        for (int c = 0; c < 40 && (sent < 6 || q.size() != 0); c++) begin
            out_ready = !(c >= 3 && c <= 7);
            in_valid  = (sent < 6);
            in_k      = codes[sent < 6 ? sent : 5];
            cur_exp   = hx(in_k);
            #1;
            if (in_valid && !in_ready && !seen_drop) begin
                seen_drop = 1'b1;
                chk("bp_buffered", 32'(q.size()), 32'd2);
            end
            hs = in_valid && in_ready;
            tick();
            if (hs) sent++;
        end
        in_valid = 1'b0;
        chk("bp_drop_seen", 32'(seen_drop), 32'd1);
        chk("bp_sent", 32'(sent), 32'd6);
        drain();

        // Write while stage B is occupied is ignored
        out_ready = 1'b0;
        send(12'h001, hx(12'h001), '0);
        tick();
        tick();
        write_row(4'd0, ~h_model[0], 1'b0, 1'b0);
        drain();
        send(12'h001, hx(12'h001), '0);
        drain();

        // Out-of-range row is ignored
        write_row(4'd13, 13'h1234, 1'b1, 1'b0);
        send(12'hFFF, hx(12'hFFF), '0);
        drain();

        // Write collides with a code: code wins, write dropped
        in_valid = 1'b1;
        in_k     = 12'h002;
        cur_exp  = hx(12'h002);
        cfg_we   = 1'b1;
        cfg_row  = 4'd1;
        cfg_data = ~h_model[1];
        #1;
        chk("collide_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("collide_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        drain();
        send(12'h002, hx(12'h002), '0);
        drain();

        // Reset with two words in flight
        send(12'h0F0, hx(12'h0F0), '0);
        send(12'h00F, hx(12'h00F), '0);
        do_reset();
        send(12'hABC, 13'h0000, '0);
        drain();

`ifdef BMF_H_DECODER_ERR_MON_EN
        for (int i = 0; i < K; i++) write_row(RW'(i), M'(1) << i, 1'b1, 1'b1);
        out_ready = 1'b0;
        send(12'h123, 13'h0123, 13'h0123);
        send(12'h456, 13'h0456, 13'h0457);
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        send(12'h789, 13'h0789, 13'h0789 ^ 13'h00B0);
        send(12'hABC, 13'h0ABC, 13'h0ABC);
        drain();
        chk("err_count", err_count, 32'd2);
        chk("err_bits", err_bits, 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
